nibble_deser: RTL and testbench
===============================

Name: nibble_deser

Overview:
Serial-to-parallel receiver for the 4-bit nibble stream produced by the team's load/shift register chain. It accepts nibbles over a valid/ready handshake and packs NIBBLES consecutive nibbles into one word, first nibble in the MSBs. It presents each word through a one-entry registered output stage with its own valid/ready handshake. The block sits at the receive end of the shift datapath and feeds word-wide consumers.

Parameters:
NIBBLES, 4, nibbles per output word; must be >= 2. Word width W = 4*NIBBLES.
TIMEOUT, 16, idle cycles allowed mid-word before a flush; must be >= 2. Used only with the optional feature.

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_nib holds a valid nibble
in_ready  output  1  block can accept a nibble this cycle (combinational)
in_nib  input  4  incoming nibble
out_valid  output  1  out_word holds a complete word
out_ready  input  1  consumer takes out_word this cycle
out_word  output  W  assembled word
timeout_err  output  1  one-cycle pulse when a partial word is flushed; constant 0 without the macro

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: cnt=0, shift reg sr=0, out_word=0, out_valid=0, timeout_err=0, idle counter=0. Reset mid-word discards the partial word and any held output word.
- Accept: acc = in_valid && in_ready.
- cnt has width $clog2(NIBBLES) and holds the number of nibbles already in sr (0..NIBBLES-1).
- last = acc && (cnt == NIBBLES-1).
- in_ready = !(out_valid && !out_ready && cnt == NIBBLES-1).
  - The block stalls only when it would complete a word while the output stage is still occupied.
  - This is a combinational path from out_ready to in_ready.
- On acc without last: sr <= {sr[W-5:0], in_nib}; cnt <= cnt+1.
- On last:
  - out_word <= {sr[W-5:0], in_nib}; out_valid <= 1; cnt <= 0; sr <= 0.
  - Latency: out_valid rises the cycle after the last nibble is accepted.
- Output handshake:
  - If out_valid && out_ready && !last, then out_valid <= 0.
  - If out_valid && out_ready && last, out_valid stays 1 and out_word takes the new word (back-to-back words, no bubble).
  - While out_valid && !out_ready, out_word is held stable.
- Throughput: one word every NIBBLES cycles under continuous in_valid and out_ready.
- in_valid gaps of any length do not disturb a partial word (without the macro).
- Nibbles offered while in_ready=0 are not consumed. The source holds in_nib and in_valid.

Optional Feature:
Macro: NIBBLE_DESER_TIMEOUT_EN.
- With the macro, a partial word is flushed after TIMEOUT idle cycles:
  - An idle counter increments each cycle with cnt != 0 && !acc.
  - The idle counter clears on acc, on flush, or whenever cnt == 0.
  - When it has counted TIMEOUT consecutive idle cycles, the next edge sets cnt <= 0, sr <= 0, idle <= 0 and timeout_err <= 1 for exactly one cycle.
  - out_valid and out_word are unaffected by the flush.
  - An acc in the cycle the count would expire takes priority; no flush occurs.
- Without the macro: no idle counter, timeout_err tied 0, TIMEOUT ignored.

Decomposition:
- Package nibble_pkg:
  - NIB_W = 4
  - typedef logic [NIB_W-1:0] nibble_t
  - function word width w(n) = NIB_W*n
- One sub-module, nib_shift_reg, is natural: parameterized W-bit shift-in register with shift enable and clear.
- Counter, handshake and output stage stay in nibble_deser.

Test Plan:
All scenarios use NIBBLES=4.
1. Nibbles A,B,C,D back-to-back with out_ready=1 -> out_word=16'hABCD; out_valid high exactly one cycle, starting the cycle after D is accepted.
2. Words 1,2,3,4 then 5,6,7,8 back-to-back with out_ready=0 -> out_word=16'h1234 held. in_ready drops while nibble 8 is offered. Raise out_ready -> 8 accepted that cycle; next cycle out_word=16'h5678.
3. out_ready=1 in the same cycle the last nibble of the next word is accepted -> out_valid stays 1 and out_word changes 16'h1234 -> 16'h5678 with no low cycle.
4. Accept 9,A, assert rst for one cycle, then feed 1,2,3,4 -> out_word=16'h1234. No word containing 9/A ever appears; all outputs are 0 the cycle after rst.
5. in_valid gaps of 5 cycles between nibbles C,0,D,E -> out_word=16'hC0DE; timeout_err stays 0.
6. With NIBBLE_DESER_TIMEOUT_EN, TIMEOUT=16: accept 7,7, then idle 16 cycles -> one-cycle timeout_err pulse. Then E,F,0,1 -> out_word=16'hEF01. The same stimulus with 15 idle cycles gives no pulse and out_word=16'h77EF.

Source files
------------

// File: rtl/nibble_deser_pkg.sv
// Shared types for the nibble deserializer slice.
// Nibble width, nibble type and word-width helper.
package nibble_pkg;

    localparam int NIB_W = 4;

    typedef logic [NIB_W-1:0] nibble_t;

    function automatic int w(input int n);
        return NIB_W * n;
    endfunction

endpackage

// File: rtl/nibble_deser_if.sv
// Nibble-in / word-out handshake bundle for nibble_deser.
// slave = deserializer side, master = source/consumer side.
interface nibble_deser_if #(
    parameter int NIBBLES = 4
);
    import nibble_pkg::*;

    localparam int W = w(NIBBLES);

    logic          in_valid;
    logic          in_ready;
    nibble_t       in_nib;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          timeout_err;

    modport master (
        output in_valid,
        output in_nib,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  timeout_err
    );

    modport slave (
        input  in_valid,
        input  in_nib,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output timeout_err
    );

endinterface

// File: rtl/nibble_deser_shift_reg.sv
// W-bit shift-in register taking one nibble per enable.
// Clear has priority over shift.
module nib_shift_reg
    import nibble_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  nibble_t      nib,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-NIB_W-1:0], nib};
        end
    end

endmodule

// File: rtl/nibble_deser.sv
// Packs NIBBLES nibbles (first in MSBs) into one word with a registered output.
// Define NIBBLE_DESER_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module nibble_deser
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    nibble_deser_if.slave  bus
);

    localparam int W  = w(NIBBLES);
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    if (NIBBLES < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("nibble_deser: NIBBLES and TIMEOUT must be >= 2");
    end

    logic [CW-1:0] cnt;
    logic [W-1:0]  sr;
    logic [W-1:0]  word_q;
    logic          valid_q;
    logic          full;
    logic          acc;
    logic          last;
    logic          flush;

    // Stall only when completing a word into an occupied output stage
    assign full         = (cnt == CNT_LAST);
    assign bus.in_ready = !(valid_q && !bus.out_ready && full);
    assign acc          = bus.in_valid && bus.in_ready;
    assign last         = acc && full;

    nib_shift_reg #(
        .W (W)
    ) u_sr (
        .clk (clk),
        .rst (rst),
        .en  (acc && !last),
        .clr (last || flush),
        .nib (bus.in_nib),
        .q   (sr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (last || flush) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (last) begin
            word_q  <= {sr[W-NIB_W-1:0], bus.in_nib};
            valid_q <= 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_word  = word_q;
    assign bus.out_valid = valid_q;

`ifdef NIBBLE_DESER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle;
    logic          err_q;

    // Flush on the edge that closes the TIMEOUT-th idle cycle
    assign flush = (cnt != '0) && !acc && (idle == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= flush;
            if (acc || flush || cnt == '0) begin
                idle <= '0;
            end else begin
                idle <= idle + 1'b1;
            end
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign flush           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_deser.sv
// Scoreboard bench for nibble_deser with NIBBLES=4, TIMEOUT=16.
// Directed nibble sequences; a negedge monitor pops expected words on transfer.
module tb_nibble_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nibble_deser_if #(.NIBBLES(4)) bus ();

    nibble_deser #(
        .NIBBLES (4),
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    int to_cycles = 0;
    logic [15:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_w = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop on every output transfer, check held word stability
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.timeout_err) to_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'h0, bus.out_word}, 32'hxxxx);
                end else begin
                    chk("word", {16'h0, bus.out_word}, {16'h0, exp_q.pop_front()});
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (hold_v) chk("hold_stable", {16'h0, bus.out_word}, {16'h0, hold_w});
                hold_v = 1'b1;
                hold_w = bus.out_word;
            end else begin
                hold_v = 1'b0;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    // Called and returns at posedge+1 phase
    task automatic send(input logic [3:0] n);
        logic rdy;
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_nib   = n;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) break;
            k++;
            if (k > 200) begin
                chk("send_timeout", 32'(k), 32'd0);
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 3; i >= 0; i--) send(t[i*4 +: 4]);
    endtask

    int base;
    int k;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_nib    = '0;
        bus.out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_word", {16'h0, bus.out_word}, 32'h0);
        chk("rst_timeout_err", {31'h0, bus.timeout_err}, 32'h0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: ABCD, out_valid for exactly one cycle
        exp_q.push_back(16'hABCD);
        send_word(16'hABCD);
        @(negedge clk);
        chk("s1_valid_rise", {31'h0, bus.out_valid}, 32'h1);
        chk("s1_word", {16'h0, bus.out_word}, 32'h0000ABCD);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s1_valid_fall", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk); #1;

        // 2: stall on the completing nibble while output is held
        bus.out_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        exp_q.push_back(16'h5678);
        send(4'h5); send(4'h6); send(4'h7);
        bus.in_valid = 1'b1;
        bus.in_nib   = 4'h8;
        @(negedge clk);
        chk("s2_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        chk("s2_held_word", {16'h0, bus.out_word}, 32'h00001234);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s2_in_ready_low2", {31'h0, bus.in_ready}, 32'h0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        #1;
        chk("s2_in_ready_comb", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("s2_valid_kept", {31'h0, bus.out_valid}, 32'h1);
        chk("s2_new_word", {16'h0, bus.out_word}, 32'h00005678);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        idle(2);

        // 3: consumer takes a word as the next one completes
        bus.out_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        exp_q.push_back(16'h5678);
        send(4'h5); send(4'h6); send(4'h7);
        bus.out_ready = 1'b1;
        send(4'h8);
        @(negedge clk);
        chk("s3_no_bubble", {31'h0, bus.out_valid}, 32'h1);
        chk("s3_word", {16'h0, bus.out_word}, 32'h00005678);
        @(posedge clk); #1;
        idle(1);

        // 4: reset mid-word discards 9,A
        send(4'h9); send(4'hA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s4_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("s4_out_word", {16'h0, bus.out_word}, 32'h0);
        chk("s4_timeout_err", {31'h0, bus.timeout_err}, 32'h0);
        @(posedge clk); #1;
        exp_q.push_back(16'h1234);
        send_word(16'h1234);
        idle(2);

        // 5: gaps inside a word
        base = to_cycles;
        exp_q.push_back(16'hC0DE);
        send(4'hC); idle(5);
        send(4'h0); idle(5);
        send(4'hD); idle(5);
        send(4'hE);
        idle(2);
        chk("s5_no_timeout", 32'(to_cycles - base), 32'd0);

`ifdef NIBBLE_DESER_TIMEOUT_EN
        // 6a: 16 idle cycles flush 7,7
        base = to_cycles;
        send(4'h7); send(4'h7);
        idle(16);
        exp_q.push_back(16'hEF01);
        send_word(16'hEF01);
        idle(2);
        chk("s6_pulse_cycles", 32'(to_cycles - base), 32'd1);

        // 6b: 15 idle cycles keep 7,7
        base = to_cycles;
        send(4'h7); send(4'h7);
        idle(15);
        exp_q.push_back(16'h77EF);
        send_word(16'hEF01);
        idle(1);
        chk("s6_no_pulse", 32'(to_cycles - base), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`else
        base = to_cycles;
        send(4'h7); send(4'h7);
        idle(20);
        chk("no_macro_no_pulse", 32'(to_cycles - base), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
